powerup_tracker: RTL and testbench

- Frame-rate controller that owns the level power-up life cycle: offer, pickup, hold timer, expiry.
- Sits upstream of the power-up icon renderer; drives its power_possible and collected_player1/collected_player2 inputs.
- Sits upstream of both bullet instances; drives the same collected_player1/collected_player2 flags, which freeze a bullet at the top of the screen.
- Resolves player/icon overlap each frame and ages the held power-up.

---
 rtl/powerup_tracker_if.sv | 50 +++++
 rtl/powerup_tracker.sv | 142 ++++++++++++++
 tb/tb_powerup_tracker.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/powerup_tracker_if.sv
// ---------------------------------------------------------------------------
// powerup_tracker_if
//   Carries the game-side inputs used by the power-up life cycle and the
//   registered flags it hands to the icon renderer and bullet instances.
//
//   Signals:
//     game_on                 1 = playing, 2 = paused, 0/3 = menu / game over
//     level                   current level number
//     Player1X/Y, Player2X/Y  player top-left positions
//     PlayerS                 player sprite side length (both players)
//     collision1/2            player hit by a bubble this frame
//     power_possible          icon exists or is in use this level
//     collected_player1/2     power-up held by that player
//     pickup_pulse            one-frame strobe on pickup
//     hold_left               remaining hold frames, 0 when not held
//
//   Modports:
//     master  game side: drives the inputs, observes the flags
//     slave   powerup_tracker: consumes the inputs, drives the flags
// ---------------------------------------------------------------------------
interface powerup_tracker_if;
  logic [1:0] game_on;
  logic [9:0] level;
  logic [9:0] Player1X;
  logic [9:0] Player1Y;
  logic [9:0] Player2X;
  logic [9:0] Player2Y;
  logic [9:0] PlayerS;
  logic       collision1;
  logic       collision2;
  logic       power_possible;
  logic       collected_player1;
  logic       collected_player2;
  logic       pickup_pulse;
  logic [9:0] hold_left;

  modport master (
    output game_on, level, Player1X, Player1Y, Player2X, Player2Y, PlayerS,
           collision1, collision2,
    input  power_possible, collected_player1, collected_player2,
           pickup_pulse, hold_left
  );

  modport slave (
    input  game_on, level, Player1X, Player1Y, Player2X, Player2Y, PlayerS,
           collision1, collision2,
    output power_possible, collected_player1, collected_player2,
           pickup_pulse, hold_left
  );
endinterface

// File: rtl/powerup_tracker.sv
// ---------------------------------------------------------------------------
// powerup_tracker
//   Frame-rate controller owning the level power-up life cycle: the icon is
//   offered on POWER_LEVEL, picked up by the first overlapping player
//   (player 1 wins ties), held for HOLD_FRAMES playing frames, and then spent
//   until the level changes. All outputs are registered.
//
//   Ports:
//     frame_clk  frame-rate clock, state updates on rising edge
//     Reset      asynchronous active-low reset
//     bus        powerup_tracker_if.slave (game inputs in, power-up flags out)
// ---------------------------------------------------------------------------
module powerup_tracker #(
  parameter int unsigned POWER_LEVEL = 2,
  parameter int unsigned ICON_X      = 100,
  parameter int unsigned ICON_Y      = 370,
  parameter int unsigned ICON_W      = 20,
  parameter int unsigned ICON_H      = 28,
  parameter int unsigned HOLD_FRAMES = 300
) (
  input  logic               frame_clk,
  input  logic               Reset,
  powerup_tracker_if.slave   bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_AVAILABLE = 3'd1;
  localparam logic [2:0] ST_HELD_P1   = 3'd2;
  localparam logic [2:0] ST_HELD_P2   = 3'd3;
  localparam logic [2:0] ST_SPENT     = 3'd4;

  localparam logic [9:0]  LEVEL_V = 10'(POWER_LEVEL);
  localparam logic [9:0]  HOLD_V  = 10'(HOLD_FRAMES);
  localparam logic [10:0] X_LO    = 11'(ICON_X);
  localparam logic [10:0] X_HI    = 11'(ICON_X + ICON_W);
  localparam logic [10:0] Y_LO    = 11'(ICON_Y);
  localparam logic [10:0] Y_HI    = 11'(ICON_Y + ICON_H);

  logic [2:0] state, state_nxt;
  logic [9:0] hold_q, hold_nxt;
  logic       power_q, col1_q, col2_q, pulse_q;
  logic       playing, paused, on_level;
  logic       overlap1, overlap2, holder_hit;

  // 11-bit sums so a player near the right/bottom edge cannot wrap around
  // and appear to overlap the icon.
  function automatic logic overlaps(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ps);
    logic [10:0] x0, y0, x1, y1;
    x0 = {1'b0, px};
    y0 = {1'b0, py};
    x1 = x0 + {1'b0, ps};
    y1 = y0 + {1'b0, ps};
    return (x0 < X_HI) && (x1 > X_LO) && (y0 < Y_HI) && (y1 > Y_LO);
  endfunction

  assign playing    = (bus.game_on == 2'd1);
  assign paused     = (bus.game_on == 2'd2);
  assign on_level   = (bus.level == LEVEL_V);
  assign overlap1   = overlaps(bus.Player1X, bus.Player1Y, bus.PlayerS);
  assign overlap2   = overlaps(bus.Player2X, bus.Player2Y, bus.PlayerS);
  assign holder_hit = (state == ST_HELD_P1) ? bus.collision1 : bus.collision2;

  // Next-state logic. The if/else chain encodes the priority: leaving the
  // game beats a level change, which beats anything the current state does.
  // Inside a held state the holder's collision is checked before expiry.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    if (!(playing || paused)) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
    end else if ((state != ST_IDLE) && !on_level) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (playing && on_level) state_nxt = ST_AVAILABLE;
        end
        ST_AVAILABLE: begin
          if (overlap1) begin
            state_nxt = ST_HELD_P1;
            hold_nxt  = HOLD_V;
          end else if (overlap2) begin
            state_nxt = ST_HELD_P2;
            hold_nxt  = HOLD_V;
          end
        end
        ST_HELD_P1, ST_HELD_P2: begin
          // The timer and the holder's collision only act while playing;
          // a pause freezes everything.
          if (playing) begin
            if (holder_hit || (hold_q <= 10'd1)) begin
              state_nxt = ST_SPENT;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold_q - 10'd1;
            end
          end
        end
        ST_SPENT: begin
          state_nxt = ST_SPENT;
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered together with
  // it, so they change on the same edge as the state they describe. The
  // pulse fires only on the AVAILABLE -> HELD edge, hence never twice in a row.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      hold_q  <= '0;
      power_q <= 1'b0;
      col1_q  <= 1'b0;
      col2_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold_q  <= hold_nxt;
      power_q <= (state_nxt == ST_AVAILABLE) || (state_nxt == ST_HELD_P1) ||
                 (state_nxt == ST_HELD_P2);
      col1_q  <= (state_nxt == ST_HELD_P1);
      col2_q  <= (state_nxt == ST_HELD_P2);
      pulse_q <= (state == ST_AVAILABLE) &&
                 ((state_nxt == ST_HELD_P1) || (state_nxt == ST_HELD_P2));
    end
  end

  assign bus.power_possible    = power_q;
  assign bus.collected_player1 = col1_q;
  assign bus.collected_player2 = col2_q;
  assign bus.pickup_pulse      = pulse_q;
  assign bus.hold_left         = hold_q;

endmodule

// File: tb/tb_powerup_tracker.sv
// ---------------------------------------------------------------------------
// tb_powerup_tracker
//   Self-checking bench for powerup_tracker: a table of per-frame vectors,
//   hand-written multi-frame sequences (expiry, pause, async reset) and a
//   randomized run compared against a behavioural life-cycle model.
// ---------------------------------------------------------------------------
module tb_powerup_tracker;

  logic frame_clk;
  logic Reset;
  int   n_compared;
  int   n_mismatched;

  powerup_tracker_if bus ();

  powerup_tracker dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [1:0] go;
    logic [9:0] lvl;
    logic [9:0] p1x, p1y, p2x, p2y;
    logic       c1, c2;
    logic       e_pp, e_c1, e_c2, e_pu;
    logic [9:0] e_hold;
  } vec_t;

  vec_t vecs [17];

  // Behavioural model state: what the player would see of the power-up.
  bit m_offered;
  bit m_spent;
  int m_holder;
  int m_timer;
  bit m_pulse;

  function automatic vec_t mkVec(int go, int lvl, int p1x, int p1y, int p2x,
                                 int p2y, int c1, int c2, int pp, int e1,
                                 int e2, int pu, int hold);
    vec_t v;
    v.go = 2'(go);   v.lvl = 10'(lvl);
    v.p1x = 10'(p1x); v.p1y = 10'(p1y); v.p2x = 10'(p2x); v.p2y = 10'(p2y);
    v.c1 = 1'(c1);   v.c2 = 1'(c2);
    v.e_pp = 1'(pp); v.e_c1 = 1'(e1); v.e_c2 = 1'(e2); v.e_pu = 1'(pu);
    v.e_hold = 10'(hold);
    return v;
  endfunction

  task automatic applyStimulus(input int go, input int lvl, input int p1x,
                               input int p1y, input int p2x, input int p2y,
                               input int ps, input int c1, input int c2);
    bus.game_on    = 2'(go);
    bus.level      = 10'(lvl);
    bus.Player1X   = 10'(p1x);
    bus.Player1Y   = 10'(p1y);
    bus.Player2X   = 10'(p2x);
    bus.Player2Y   = 10'(p2y);
    bus.PlayerS    = 10'(ps);
    bus.collision1 = 1'(c1);
    bus.collision2 = 1'(c2);
  endtask

  task automatic checkField(input string nm, input string field,
                            input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", nm, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string nm, input int pp, input int c1,
                             input int c2, input int pu, input int hold);
    checkField(nm, "power_possible", int'(bus.power_possible), pp);
    checkField(nm, "collected_player1", int'(bus.collected_player1), c1);
    checkField(nm, "collected_player2", int'(bus.collected_player2), c2);
    checkField(nm, "pickup_pulse", int'(bus.pickup_pulse), pu);
    checkField(nm, "hold_left", int'(bus.hold_left), hold);
  endtask

  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic bit hits(int x, int y, int s);
    return (x < 120) && (x + s > 100) && (y < 398) && (y + s > 370);
  endfunction

  function automatic void modelClear();
    m_offered = 0; m_spent = 0; m_holder = 0; m_timer = 0; m_pulse = 0;
  endfunction

  // One frame of the power-up life cycle, applied rule by rule in priority order.
  function automatic void modelStep(int go, int lvl, int p1x, int p1y,
                                    int p2x, int p2y, int s, int c1, int c2);
    bit active;
    active  = m_offered || m_spent || (m_holder != 0);
    m_pulse = 0;
    if (go == 0 || go == 3) begin
      modelClear();
    end else if (lvl != 2 && active) begin
      modelClear();
    end else if (m_holder != 0) begin
      if (go == 1) begin
        if ((m_holder == 1 && c1 != 0) || (m_holder == 2 && c2 != 0)) begin
          m_holder = 0; m_timer = 0; m_spent = 1;
        end else begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin
            m_holder = 0; m_spent = 1;
          end
        end
      end
    end else if (m_offered) begin
      if (hits(p1x, p1y, s)) begin
        m_holder = 1; m_timer = 300; m_offered = 0; m_pulse = 1;
      end else if (hits(p2x, p2y, s)) begin
        m_holder = 2; m_timer = 300; m_offered = 0; m_pulse = 1;
      end
    end else if (!m_spent && go == 1 && lvl == 2) begin
      m_offered = 1;
    end
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    vecs[0]  = mkVec(1, 2,   0,   0, 300,   0, 0, 0, 1, 0, 0, 0,   0);
    vecs[1]  = mkVec(1, 2, 105, 360, 300,   0, 0, 0, 1, 1, 0, 1, 300);
    vecs[2]  = mkVec(1, 2, 105, 360, 300,   0, 0, 0, 1, 1, 0, 0, 299);
    vecs[3]  = mkVec(2, 2, 105, 360, 300,   0, 0, 0, 1, 1, 0, 0, 299);
    vecs[4]  = mkVec(1, 2, 105, 360, 300,   0, 0, 1, 1, 1, 0, 0, 298);
    vecs[5]  = mkVec(2, 2, 105, 360, 300,   0, 1, 0, 1, 1, 0, 0, 298);
    vecs[6]  = mkVec(1, 2, 105, 360, 300,   0, 1, 0, 0, 0, 0, 0,   0);
    vecs[7]  = mkVec(1, 2, 105, 360, 300,   0, 0, 0, 0, 0, 0, 0,   0);
    vecs[8]  = mkVec(1, 3, 105, 360, 300,   0, 0, 0, 0, 0, 0, 0,   0);
    vecs[9]  = mkVec(1, 2,  90, 360, 110, 360, 0, 0, 1, 0, 0, 0,   0);
    vecs[10] = mkVec(1, 2,  90, 360, 110, 360, 0, 0, 1, 1, 0, 1, 300);
    vecs[11] = mkVec(1, 3,  90, 360, 110, 360, 0, 0, 0, 0, 0, 0,   0);
    vecs[12] = mkVec(1, 2,   0,   0, 300,   0, 0, 0, 1, 0, 0, 0,   0);
    vecs[13] = mkVec(1, 2,   0,   0, 110, 360, 0, 0, 1, 0, 1, 1, 300);
    vecs[14] = mkVec(0, 2,   0,   0, 110, 360, 0, 0, 0, 0, 0, 0,   0);
    vecs[15] = mkVec(1, 2,   0,   0, 300,   0, 0, 0, 1, 0, 0, 0,   0);
    vecs[16] = mkVec(3, 2,   0,   0, 300,   0, 0, 0, 0, 0, 0, 0,   0);

    // Reset state
    Reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 300, 0, 40, 0, 0);
    frame();
    frame();
    checkOutput("reset", 0, 0, 0, 0, 0);
    @(negedge frame_clk);
    Reset = 1'b1;

    // Vector table
    for (int i = 0; i < 17; i++) begin
      applyStimulus(int'(vecs[i].go), int'(vecs[i].lvl), int'(vecs[i].p1x),
                    int'(vecs[i].p1y), int'(vecs[i].p2x), int'(vecs[i].p2y),
                    40, int'(vecs[i].c1), int'(vecs[i].c2));
      frame();
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].e_pp),
                  int'(vecs[i].e_c1), int'(vecs[i].e_c2), int'(vecs[i].e_pu),
                  int'(vecs[i].e_hold));
    end

    // Full hold expiry for player 1
    applyStimulus(1, 2, 105, 360, 300, 0, 40, 0, 0);
    frame();
    checkOutput("expiry_offer", 1, 0, 0, 0, 0);
    frame();
    checkOutput("expiry_pickup", 1, 1, 0, 1, 300);
    for (int k = 1; k < 300; k++) begin
      frame();
      checkField("expiry_count", "hold_left", int'(bus.hold_left), 300 - k);
      if (k == 1)   checkOutput("expiry_first", 1, 1, 0, 0, 299);
      if (k == 299) checkOutput("expiry_last", 1, 1, 0, 0, 1);
    end
    frame();
    checkOutput("expiry_done", 0, 0, 0, 0, 0);
    frame();
    checkOutput("expiry_spent", 0, 0, 0, 0, 0);

    // Player 2 hold frozen by pause
    applyStimulus(1, 3, 0, 0, 300, 0, 40, 0, 0);
    frame();
    applyStimulus(1, 2, 0, 0, 110, 360, 40, 0, 0);
    frame();
    frame();
    checkOutput("p2_pickup", 1, 0, 1, 1, 300);
    repeat (150) frame();
    checkOutput("p2_run", 1, 0, 1, 0, 150);
    applyStimulus(2, 2, 0, 0, 110, 360, 40, 0, 0);
    repeat (50) frame();
    checkOutput("p2_paused", 1, 0, 1, 0, 150);
    applyStimulus(1, 2, 0, 0, 110, 360, 40, 0, 0);
    frame();
    checkOutput("p2_resume", 1, 0, 1, 0, 149);

    // Asynchronous reset while held
    @(negedge frame_clk);
    Reset = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0);
    @(negedge frame_clk);
    Reset = 1'b1;
    modelClear();

    // Randomized run against the behavioural model
    begin
      bit prev_pulse;
      prev_pulse = 0;
      for (int n = 0; n < 4000; n++) begin
        int go, lvl, p1x, p1y, p2x, p2y, s, c1, c2, r;
        r   = int'($urandom_range(0, 99));
        go  = (r < 85) ? 1 : (r < 95) ? 2 : (r < 97) ? 0 : 3;
        lvl = ($urandom_range(0, 99) < 4) ? 3 : 2;
        p1x = int'($urandom_range(40, 180));
        p1y = int'($urandom_range(320, 420));
        p2x = int'($urandom_range(40, 180));
        p2y = int'($urandom_range(320, 420));
        s   = int'($urandom_range(8, 40));
        c1  = ($urandom_range(0, 99) < 2) ? 1 : 0;
        c2  = ($urandom_range(0, 99) < 2) ? 1 : 0;
        applyStimulus(go, lvl, p1x, p1y, p2x, p2y, s, c1, c2);
        frame();
        modelStep(go, lvl, p1x, p1y, p2x, p2y, s, c1, c2);
        checkOutput($sformatf("rand%0d", n), int'(m_offered || m_holder != 0),
                    int'(m_holder == 1), int'(m_holder == 2), int'(m_pulse),
                    m_timer);
        n_compared++;
        if (bus.collected_player1 && bus.collected_player2) begin
          n_mismatched++;
          $display("[TB] FAIL rand%0d both_collected: got 1, expected 0", n);
        end
        n_compared++;
        if (prev_pulse && bus.pickup_pulse) begin
          n_mismatched++;
          $display("[TB] FAIL rand%0d pulse_twice: got 1, expected 0", n);
        end
        prev_pulse = bus.pickup_pulse;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared,
             n_mismatched);
    $finish;
  end

endmodule
